arcfour_sweep_core: RTL and testbench
=====================================

Name: arcfour_sweep_core

Overview:
- Self-contained RC4 key-search engine; successor to the fixed-key arcfour controller.
- Runs KSA and PRGA directly against the S working RAM, the encrypted-message ROM and the decrypted-output RAM.
- Steps through a key range of base, base+stride, base+2·stride, … up to a limit.
- Stops on the first key whose plaintext is all lowercase ASCII or space.
- Key width and message length are parameters; stride lets N cores split one keyspace.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..16); key byte 0 is the most-significant byte of the key vector.
- KEY_BITS, 24, number of searched key bits (≤ 8·KEY_BYTES); the upper bits are held at 0.
- MSG_LEN, 32, message length in bytes (1..256).
- MSG_AW, 5, message address width; must satisfy 2^MSG_AW ≥ MSG_LEN.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; accepted only in IDLE
- abort  in  1  level; forces return to IDLE
- key_base  in  KEY_BITS  first candidate key
- key_stride  in  KEY_BITS  increment between candidates (≥1)
- key_limit  in  KEY_BITS  last permitted candidate
- s_addr  out  8  S RAM address
- s_din  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_dout  in  8  S RAM read data (1-cycle latency)
- k_addr  out  MSG_AW  message ROM address
- k_dout  in  8  ROM data (1-cycle latency)
- a_addr  out  MSG_AW  output RAM address
- a_din  out  8  output RAM write data
- a_wren  out  1  output RAM write enable
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of search
- found  out  1  sticky until next accepted start
- found_key  out  KEY_BITS  winning key, valid while found=1
- cur_key  out  KEY_BITS  candidate currently under test

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all write enables 0; busy, done, found = 0; found_key, cur_key, all addresses and all data outputs = 0.
- Reset deasserts synchronously to clk.
- States: IDLE, LOAD, INIT, SHUF, DECR, CHECK, NEXT.
- IDLE, start=1: cur_key←key_base; found←0; go to LOAD.
- LOAD: 1 cycle; clears i, j and the valid flag.
- INIT: 256 cycles; S[i]←i for i=0..255 (s_wren=1).
- SHUF: 5 cycles per i, i=0..255 (1280 cycles total), j starts at 0:
  - c0: read S[i].
  - c1: capture si; j←j+si+key[i mod KEY_BYTES] (mod 256).
  - c2: read S[j].
  - c3: capture sj; write S[j]←si.
  - c4: write S[i]←sj.
  - When i=j, the c4 write wins.
- DECR: 7 cycles per message byte k=0..MSG_LEN-1. i, j are reset to 0 at entry; i←i+1 at the start of each byte. k_addr=k is held for all 7 cycles.
  - c0: read S[i].
  - c1: capture si; j←j+si.
  - c2: read S[j].
  - c3: capture sj; write S[j]←si.
  - c4: write S[i]←sj.
  - c5: read S[(si+sj) mod 256].
  - c6: f captured; a_din=f^k_dout; a_wren=1 at a_addr=k; the byte is checked.
  - A byte is valid iff it is 0x20 or in 0x61..0x7A. Any invalid byte clears the valid flag.
- CHECK: 1 cycle.
  - valid=1: found←1, found_key←cur_key, done pulse, go to IDLE.
  - Otherwise go to NEXT.
- NEXT: 1 cycle.
  - If cur_key+key_stride > key_limit, or the KEY_BITS-wide add overflows: done pulse with found=0, go to IDLE.
  - Else cur_key←cur_key+key_stride, go to LOAD.
- Per-key latency without early abort: 1+256+1280+7·MSG_LEN+2 cycles.
- key_base > key_limit: the base key is still tested once.
- abort=1 in any non-IDLE state: next cycle IDLE, all write enables 0, no done pulse, found unchanged. abort has priority over start.
- s_wren and a_wren are never both asserted in the same cycle.

Optional Feature:
- Macro ARCFOUR_EARLY_ABORT_EN.
- Defined: the first invalid byte in DECR skips the remaining bytes and goes directly to NEXT. Partially decrypted bytes remain in the output RAM.
- Undefined: all MSG_LEN bytes are always decrypted and written, then CHECK decides.

Test Plan:
- Known vector: KEY_BYTES=3, key_base=key_limit=24'h000018, ROM holds the RC4 encryption under that key of a 32-byte lowercase/space sentence -> found=1, found_key=24'h000018, output RAM equals the plaintext, done at cycle 1+256+1280+224+2 after start.
- Sweep: key_base=0, stride=1, limit=0x20, true key 0x18 -> exactly 25 done-free key passes (keys 0x00..0x18), found_key=0x18, cur_key=0x18.
- Exhaustion: ROM content with no valid key, base=0, stride=4, limit=0x0A -> keys 0, 4 and 8 are tested; done pulse with found=0.
- Overflow: KEY_BITS=24, base=24'hFFFFFE, stride=4, limit=24'hFFFFFF -> one key tested, then done with found=0 and no wrap to low keys.
- Abort: assert abort during SHUF of the second key -> busy=0 next cycle, no writes afterwards, no done pulse; a new start restarts from key_base.
- Async reset: drive reset_n low mid-DECR between clock edges -> all outputs 0 immediately. With ARCFOUR_EARLY_ABORT_EN, the wrong-key pass length is 1+256+1280+7·(index of first invalid byte+1)+1 cycles.

Source files
------------

// File: rtl/arcfour_sweep_core.sv
// arcfour_sweep_core: RC4 key-search engine sweeping base, base+stride, ... up to limit.
// Define ARCFOUR_EARLY_ABORT_EN to abandon a candidate at its first non-lowercase byte.
`timescale 1ns/1ps
module arcfour_sweep_core #(
    parameter int KEY_BYTES = 3,
    parameter int KEY_BITS  = 24,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_BITS-1:0] key_base,
    input  logic [KEY_BITS-1:0] key_stride,
    input  logic [KEY_BITS-1:0] key_limit,
    output logic [7:0]          s_addr,
    output logic [7:0]          s_din,
    output logic                s_wren,
    input  logic [7:0]          s_dout,
    output logic [MSG_AW-1:0]   k_addr,
    input  logic [7:0]          k_dout,
    output logic [MSG_AW-1:0]   a_addr,
    output logic [7:0]          a_din,
    output logic                a_wren,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [KEY_BITS-1:0] found_key,
    output logic [KEY_BITS-1:0] cur_key
);
    localparam int KW = KEY_BYTES * 8;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, INIT = 3'd2, SHUF = 3'd3,
                           DECR = 3'd4, CHECK = 3'd5, NEXT = 3'd6;
    localparam logic [MSG_AW-1:0] LAST = MSG_AW'(MSG_LEN - 1);

    logic [2:0]          state, cyc;
    logic [7:0]          i, j, si, sj, kbyte, pt;
    logic [3:0]          kidx;
    logic [MSG_AW-1:0]   k;
    logic                bad, pt_ok;
    logic [KW-1:0]       key_vec;
    logic [KEY_BITS:0]   nxt;

    assign key_vec = KW'(cur_key);
    assign nxt     = {1'b0, cur_key} + {1'b0, key_stride};
    assign pt      = s_dout ^ k_dout;
    assign pt_ok   = pt == 8'h20 || (pt >= 8'h61 && pt <= 8'h7a);
    assign busy    = state != IDLE;

    // key byte 0 sits in the most-significant byte of the key vector
    always_comb begin
        kbyte = 8'd0;
        for (int b = 0; b < KEY_BYTES; b++)
            if (kidx == 4'(b)) kbyte = key_vec[(KEY_BYTES-1-b)*8 +: 8];
    end

    always_comb begin
        s_addr = 8'd0;
        s_din  = 8'd0;
        s_wren = 1'b0;
        k_addr = '0;
        a_addr = '0;
        a_din  = 8'd0;
        a_wren = 1'b0;
        if (state == INIT) begin
            s_addr = i;
            s_din  = i;
            s_wren = 1'b1;
        end else if (state == SHUF || state == DECR) begin
            s_addr = (state == DECR && cyc == 3'd5) ? si + sj : (cyc == 3'd2 || cyc == 3'd3) ? j : i;
            s_din  = cyc == 3'd3 ? si : cyc == 3'd4 ? sj : 8'd0;
            s_wren = cyc == 3'd3 || cyc == 3'd4;
        end
        if (state == DECR) begin
            k_addr = k;
            a_addr = k;
            a_din  = cyc == 3'd6 ? pt : 8'd0;
            a_wren = cyc == 3'd6;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cyc       <= 3'd0;
            i         <= 8'd0;
            j         <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            kidx      <= 4'd0;
            k         <= '0;
            bad       <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            found_key <= '0;
            cur_key   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        cur_key <= key_base;
                        found   <= 1'b0;
                        state   <= LOAD;
                    end
                    LOAD: begin
                        i     <= 8'd0;
                        j     <= 8'd0;
                        cyc   <= 3'd0;
                        kidx  <= 4'd0;
                        k     <= '0;
                        bad   <= 1'b0;
                        state <= INIT;
                    end
                    INIT: begin
                        i <= i + 8'd1;
                        if (i == 8'hff) state <= SHUF;
                    end
                    SHUF: begin
                        cyc <= cyc == 3'd4 ? 3'd0 : cyc + 3'd1;
                        if (cyc == 3'd1) begin
                            si <= s_dout;
                            j  <= j + s_dout + kbyte;
                        end
                        if (cyc == 3'd3) sj <= s_dout;
                        if (cyc == 3'd4) begin
                            i    <= i + 8'd1;
                            kidx <= kidx == 4'(KEY_BYTES - 1) ? 4'd0 : kidx + 4'd1;
                            // PRGA pre-increments i, so the first byte starts at i=1, j=0
                            if (i == 8'hff) begin
                                state <= DECR;
                                i     <= 8'd1;
                                j     <= 8'd0;
                            end
                        end
                    end
                    DECR: begin
                        cyc <= cyc == 3'd6 ? 3'd0 : cyc + 3'd1;
                        if (cyc == 3'd1) begin
                            si <= s_dout;
                            j  <= j + s_dout;
                        end
                        if (cyc == 3'd3) sj <= s_dout;
                        if (cyc == 3'd6) begin
                            i <= i + 8'd1;
                            k <= k + MSG_AW'(1);
                            if (!pt_ok) bad <= 1'b1;
`ifdef ARCFOUR_EARLY_ABORT_EN
                            if (!pt_ok) state <= NEXT;
                            else if (k == LAST) state <= CHECK;
`else
                            if (k == LAST) state <= CHECK;
`endif
                        end
                    end
                    CHECK: if (!bad) begin
                        found     <= 1'b1;
                        found_key <= cur_key;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= NEXT;
                    end
                    NEXT: if (nxt[KEY_BITS] || nxt[KEY_BITS-1:0] > key_limit) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cur_key <= nxt[KEY_BITS-1:0];
                        state   <= LOAD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_arcfour_sweep_core.sv
// tb_arcfour_sweep_core: randomized bench for arcfour_sweep_core against a software RC4 search model.
`timescale 1ns/1ps
module tb_arcfour_sweep_core;
    localparam int KB    = 3;
    localparam int KBITS = 24;
    localparam int ML    = 32;
    localparam int AW    = 5;
    localparam int PASS  = 1 + 256 + 1280 + 7 * ML;

    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, abort = 1'b0;
    logic [KBITS-1:0] key_base = '0, key_stride = 24'd1, key_limit = '0;
    logic [7:0] s_addr, s_din, s_dout, k_dout, a_din;
    logic s_wren, a_wren, busy, done, found;
    logic [AW-1:0] k_addr, a_addr;
    logic [KBITS-1:0] found_key, cur_key;
    logic [86:0] outs;

    logic [7:0] s_mem [256];
    logic [7:0] rom [ML];
    logic [7:0] out_mem [ML];
    logic [7:0] pt [ML];
    int ks [ML];

    int tests = 0, fails = 0;
    logic [KBITS-1:0] got_keys [$];
    logic [KBITS-1:0] exp_keys [$];
    int run_n, exp_n;
    bit run_done, run_overlap, exp_found;
    logic [KBITS-1:0] exp_key;

    always #5 clk = ~clk;

    arcfour_sweep_core #(.KEY_BYTES(KB), .KEY_BITS(KBITS), .MSG_LEN(ML), .MSG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .key_base(key_base), .key_stride(key_stride), .key_limit(key_limit),
        .s_addr(s_addr), .s_din(s_din), .s_wren(s_wren), .s_dout(s_dout),
        .k_addr(k_addr), .k_dout(k_dout),
        .a_addr(a_addr), .a_din(a_din), .a_wren(a_wren),
        .busy(busy), .done(done), .found(found), .found_key(found_key), .cur_key(cur_key)
    );

    assign outs = {busy, done, found, found_key, cur_key, s_addr, s_din, s_wren, k_addr, a_addr, a_din, a_wren};

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_din;
        s_dout <= s_mem[s_addr];
        k_dout <= rom[k_addr];
        if (a_wren) out_mem[a_addr] <= a_din;
    end

    function automatic bit is_ok(int p);
        return p == 32 || (p >= 97 && p <= 122);
    endfunction

    // textbook RC4: KSA then PRGA, keystream into ks[]
    function automatic void gen_ks(input logic [KBITS-1:0] key);
        int s [256];
        int j, t, x;
        logic [127:0] kv;
        kv = 128'(key);
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(kv[8*(KB-1-(n%KB)) +: 8])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        x = 0;
        j = 0;
        for (int n = 0; n < ML; n++) begin
            x = (x + 1) % 256;
            j = (j + s[x]) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
            ks[n] = s[(s[x] + s[j]) % 256];
        end
    endfunction

    function automatic int first_bad(input logic [KBITS-1:0] key);
        gen_ks(key);
        for (int n = 0; n < ML; n++)
            if (!is_ok(int'(rom[n]) ^ ks[n])) return n;
        return ML;
    endfunction

    function automatic int wrong_len(int fb);
`ifdef ARCFOUR_EARLY_ABORT_EN
        return 1 + 256 + 1280 + 7 * (fb + 1) + 1;
`else
        return PASS + 2 + 0 * fb;
`endif
    endfunction

    task automatic make_rom(input logic [KBITS-1:0] key, input bit valid_pt);
        for (int n = 0; n < ML; n++) begin
            if (valid_pt) pt[n] = ($urandom_range(0, 26) == 26) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
            else pt[n] = 8'($urandom);
        end
        gen_ks(key);
        for (int n = 0; n < ML; n++) rom[n] = pt[n] ^ 8'(ks[n]);
    endtask

    task automatic model_search(input logic [KBITS-1:0] base, input logic [KBITS-1:0] stride, input logic [KBITS-1:0] limit);
        longint kk;
        int fb;
        kk = longint'(base);
        exp_keys.delete();
        exp_found = 0;
        exp_key = '0;
        exp_n = 1;
        forever begin
            exp_keys.push_back(KBITS'(kk));
            fb = first_bad(KBITS'(kk));
            if (fb == ML) begin
                exp_found = 1;
                exp_key = KBITS'(kk);
                exp_n += PASS + 1;
                break;
            end
            exp_n += wrong_len(fb);
            kk += longint'(stride);
            if (kk > longint'(limit) || kk >= (longint'(1) << KBITS)) break;
        end
    endtask

    task automatic run_search(input logic [KBITS-1:0] base, input logic [KBITS-1:0] stride, input logic [KBITS-1:0] limit, input int bound);
        key_base = base;
        key_stride = stride;
        key_limit = limit;
        start = 1'b1;
        got_keys.delete();
        run_n = 0;
        run_done = 0;
        run_overlap = 0;
        while (!run_done && run_n < bound) begin
            @(posedge clk);
            run_n++;
            #1;
            start = 1'b0;
            if (got_keys.size() == 0 || got_keys[$] != cur_key) got_keys.push_back(cur_key);
            if (s_wren && a_wren) run_overlap = 1;
            if (done) run_done = 1;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_async_outputs: got %h want 0", outs); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_idle_hold: got %h want 0", outs); end
    endtask

    task automatic test_known_vector();
        bit same;
        make_rom(24'h000018, 1);
        model_search(24'h18, 24'h1, 24'h18);
        run_search(24'h18, 24'h1, 24'h18, exp_n + 50);
        tests++;
        if (!run_done) begin fails++; $display("FAIL known_timeout: got no done after %0d cycles", run_n); end
        tests++;
        if (run_n !== 1 + 256 + 1280 + 224 + 2) begin fails++; $display("FAIL known_latency: got %0d want %0d", run_n, 1 + 256 + 1280 + 224 + 2); end
        tests++;
        if (found !== 1'b1 || found_key !== 24'h18) begin fails++; $display("FAIL known_found: got found=%b key=%h want found=1 key=000018", found, found_key); end
        same = 1;
        for (int n = 0; n < ML; n++) if (out_mem[n] !== pt[n]) same = 0;
        tests++;
        if (!same) begin fails++; $display("FAIL known_plaintext: got %h want %h at byte 0", out_mem[0], pt[0]); end
        tests++;
        if (run_overlap) begin fails++; $display("FAIL known_wren_overlap: got s_wren&a_wren=1 want never"); end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || found !== 1'b1) begin fails++; $display("FAIL known_done_pulse: got done=%b busy=%b found=%b want 0 0 1", done, busy, found); end
    endtask

    task automatic check_run(input string name, input bit chk_key);
        bit same;
        tests++;
        if (!run_done || run_n !== exp_n) begin fails++; $display("FAIL %s_latency: got done=%b cycles=%0d want done=1 cycles=%0d", name, run_done, run_n, exp_n); end
        same = got_keys.size() == exp_keys.size();
        for (int q = 0; q < exp_keys.size() && same; q++) same = got_keys[q] === exp_keys[q];
        tests++;
        if (!same) begin fails++; $display("FAIL %s_keys: got %0d keys (last %h) want %0d keys (last %h)", name, got_keys.size(), got_keys[$], exp_keys.size(), exp_keys[$]); end
        tests++;
        if (found !== exp_found || cur_key !== exp_keys[$]) begin fails++; $display("FAIL %s_result: got found=%b cur_key=%h want found=%b cur_key=%h", name, found, cur_key, exp_found, exp_keys[$]); end
        if (chk_key) begin
            tests++;
            if (found_key !== exp_key) begin fails++; $display("FAIL %s_found_key: got %h want %h", name, found_key, exp_key); end
        end
    endtask

    task automatic test_sweep();
        model_search(24'h0, 24'h1, 24'h20);
        run_search(24'h0, 24'h1, 24'h20, exp_n + 50);
        check_run("sweep", 1);
        tests++;
        if (got_keys.size() != 25 || found_key !== 24'h18) begin fails++; $display("FAIL sweep_passes: got %0d passes key %h want 25 passes key 000018", got_keys.size(), found_key); end
    endtask

    task automatic test_exhaustion();
        make_rom(24'h18, 0);
        model_search(24'h0, 24'h4, 24'h0A);
        run_search(24'h0, 24'h4, 24'h0A, exp_n + 50);
        check_run("exhaust", 0);
    endtask

    task automatic test_overflow();
        model_search(24'hFFFFFE, 24'h4, 24'hFFFFFF);
        run_search(24'hFFFFFE, 24'h4, 24'hFFFFFF, exp_n + 50);
        check_run("overflow", 0);
    endtask

    task automatic test_abort();
        int target, wr, dn;
        for (int n = 0; n < ML; n++) rom[n] = 8'($urandom);
        target = wrong_len(first_bad(24'h0)) + 258 + int'($urandom_range(0, 1278));
        key_base = 24'h0;
        key_stride = 24'h1;
        key_limit = 24'h20;
        start = 1'b1;
        dn = 0;
        for (int n = 1; n <= target; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) dn++;
        end
        tests++;
        if (cur_key !== 24'h1 || busy !== 1'b1) begin fails++; $display("FAIL abort_setup: got cur_key=%h busy=%b want 000001 1", cur_key, busy); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({busy, s_wren, a_wren} !== 3'b000) begin fails++; $display("FAIL abort_idle: got busy/s_wren/a_wren=%b want 000", {busy, s_wren, a_wren}); end
        start = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_priority: got busy=%b want 0", busy); end
        abort = 1'b0;
        start = 1'b0;
        wr = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (s_wren || a_wren) wr++;
            if (done) dn++;
        end
        tests++;
        if (wr != 0 || dn != 0) begin fails++; $display("FAIL abort_quiet: got writes=%0d dones=%0d want 0 0", wr, dn); end
        tests++;
        if (found !== 1'b0) begin fails++; $display("FAIL abort_found: got %b want 0", found); end
        key_base = 24'h7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (cur_key !== 24'h7 || busy !== 1'b1) begin fails++; $display("FAIL abort_restart: got cur_key=%h busy=%b want 000007 1", cur_key, busy); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        int target;
        make_rom(24'h18, 1);
        key_base = 24'h18;
        key_stride = 24'h1;
        key_limit = 24'h18;
        start = 1'b1;
        target = 1 + 256 + 1280 + int'($urandom_range(1, 200));
        for (int n = 1; n <= target; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL areset_setup: got busy=%b want 1", busy); end
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL areset_immediate: got %h want 0", outs); end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || s_wren !== 1'b0) begin fails++; $display("FAIL areset_release: got busy=%b s_wren=%b want 0 0", busy, s_wren); end
    endtask

    task automatic test_random();
        logic [KBITS-1:0] kt, stride, base, limit;
        bit same;
        kt = KBITS'($urandom_range(32'h100, 32'hFFFF00));
        stride = KBITS'($urandom_range(1, 3));
        base = kt - stride * KBITS'($urandom_range(0, 2));
        limit = kt + KBITS'($urandom_range(0, 5));
        make_rom(kt, 1);
        model_search(base, stride, limit);
        run_search(base, stride, limit, exp_n + 50);
        check_run("random", 1);
        same = 1;
        for (int n = 0; n < ML; n++) if (out_mem[n] !== pt[n]) same = 0;
        tests++;
        if (!same) begin fails++; $display("FAIL random_plaintext: got %h want %h at byte 0 (key %h)", out_mem[0], pt[0], kt); end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_sweep();
        test_exhaustion();
        test_overflow();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
